// File: rtl/tick_gen_pkg.sv
// tick_gen_pkg: shared constants and helpers for the tick_gen strobe generator.
// Revision 1.0
`default_nettype none

package tick_gen_pkg;

  // Smallest divisor that still leaves a distinct last-count value.
  localparam int DIV_MIN = 2;

  function automatic int clog2_div(input int clk_hz, input int tick_hz);
    return $clog2(clk_hz / tick_hz + 1);
  endfunction

  function automatic logic [31:0] clamp_div(input logic [31:0] div);
    return (div < 32'(DIV_MIN)) ? 32'(DIV_MIN) : div;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tick_gen.sv
// tick_gen: programmable one-cycle enable strobe with runtime divisor and phase clear.
// Revision 1.0 -- optional square-wave output enabled by TICK_GEN_SQUARE_EN.
`default_nettype none

module tick_gen
  import tick_gen_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 1,
  parameter int CNT_W   = clog2_div(CLK_HZ, TICK_HZ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync_clr,
  input  logic             div_load,
  input  logic [CNT_W-1:0] div_val,
  output logic             tick,
  output logic [CNT_W-1:0] cnt,
  output logic             div_pend
`ifdef TICK_GEN_SQUARE_EN
  ,
  output logic             sq_out
`endif
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(clamp_div(32'(CLK_HZ / TICK_HZ)));

  logic [CNT_W-1:0] div_cur;
  logic [CNT_W-1:0] div_nxt;
  logic [CNT_W-1:0] div_val_c;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] cnt_last;
  logic             at_last;
  logic             wrap;
  logic             apply;

  assign div_val_c = CNT_W'(clamp_div(32'(div_val)));
  assign cnt_inc   = cnt + CNT_W'(1);
  // Clamped divisor is >= 2, so this never underflows.
  assign cnt_last  = div_cur - CNT_W'(1);
  assign at_last   = (cnt == cnt_last);
  assign wrap      = en & at_last & ~sync_clr;
  assign apply     = div_pend & (sync_clr | wrap);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      tick     <= 1'b0;
      div_cur  <= DIV_RST;
      div_nxt  <= DIV_RST;
      div_pend <= 1'b0;
    end else begin
      tick <= wrap;

      if (sync_clr || wrap) begin
        cnt <= '0;
      end else if (en) begin
        cnt <= cnt_inc;
      end

      if (apply) begin
        div_cur <= div_nxt;
      end

      // A load on the apply edge is staged for the following period.
      if (div_load) begin
        div_nxt  <= div_val_c;
        div_pend <= 1'b1;
      end else if (apply) begin
        div_pend <= 1'b0;
      end
    end
  end

`ifdef TICK_GEN_SQUARE_EN
  logic [CNT_W-1:0] sq_half;

  assign sq_half = div_cur >> 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sq_out <= 1'b0;
    end else if (sync_clr || wrap) begin
      sq_out <= 1'b0;
    end else if (en && (cnt_inc == sq_half)) begin
      sq_out <= 1'b1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: doc/tick_gen.md
Name: tick_gen

Overview:
Parametrised successor to the fixed 100 MHz-to-1 Hz divider. It generates a one-cycle enable strobe at a programmable rate instead of a derived clock, so downstream logic stays on the single system clock. The divisor can be changed at runtime, the phase can be cleared synchronously (used when a button sets the time), and the counter can be paused. It feeds the seconds counter and the seven-segment refresh logic of the clock design.

Parameters:
- CLK_HZ, 100_000_000, input clock frequency in Hz.
- TICK_HZ, 1, default strobe rate in Hz; default divisor DIV_RST = CLK_HZ/TICK_HZ, integer division.
- CNT_W, $clog2(CLK_HZ/TICK_HZ + 1), counter and divisor width; an override must be >= this value.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  count enable; low freezes the counter.
- sync_clr  in  1  synchronous phase clear.
- div_load  in  1  single-cycle request to change the divisor.
- div_val  in  CNT_W  new divisor; sampled only when div_load=1.
- tick  out  1  registered strobe, high for exactly one cycle per period.
- cnt  out  CNT_W  current counter value, 0..div_cur-1.
- div_pend  out  1  high while a loaded divisor is waiting to be applied.
- sq_out  out  1  square wave; present only with the optional feature.

Behaviour:
- Reset (rst_n=0, asynchronous): cnt=0, tick=0, div_pend=0, div_cur=DIV_RST, div_nxt=DIV_RST, sq_out=0.
- Divisor clamp: an effective divisor below 2 is forced to 2. This applies to both DIV_RST and div_val.
- Counting: when en=1, cnt increments each cycle. When cnt==div_cur-1, cnt wraps to 0 on the next edge, and tick=1 in the cycle after that edge. Otherwise tick=0.
- Period: exactly div_cur enabled cycles between successive tick assertions.
- Pause: when en=0, cnt holds and tick=0. Resuming continues from the held cnt; no tick is lost or duplicated.
- Divisor load: on div_load=1, div_nxt<=clamp(div_val) and div_pend<=1. The new value takes effect at the next wrap edge or the next sync_clr, whichever comes first. At that edge, div_cur<=div_nxt and div_pend<=0.
- Back-to-back loads: the last div_load before the apply edge wins.
- Load on the wrap edge itself: the wrap uses the old div_nxt (or div_cur if nothing is pending). The new value stays pending until the next wrap.
- sync_clr=1 (priority over en): cnt<=0 and tick=0 next cycle, with no strobe. Any pending divisor is applied at the same edge.
- sync_clr and div_load in the same cycle: cnt<=0 and div_cur<=div_cur_old_pending_or_current. The new div_val becomes pending (div_pend=1).
- Reset mid-period: everything returns to reset values and pending loads are discarded.
- Arithmetic: unsigned, CNT_W bits. The compare is against div_cur-1 computed in CNT_W bits, which cannot underflow because of the clamp.

Optional Feature:
- Macro: TICK_GEN_SQUARE_EN.
- Defined:
  - sq_out exists.
  - sq_out<=0 when cnt wraps to 0.
  - sq_out<=1 when cnt reaches div_cur>>1.
  - Result: period div_cur; low for floor(div_cur/2) cycles, high for the remainder.
  - sq_out holds when en=0; forced to 0 by reset and by sync_clr.
- Undefined: no sq_out port and no associated logic.

Decomposition:
- Package tick_gen_pkg holds:
  - constant DIV_MIN=2;
  - function clog2_div(clk_hz, tick_hz) returning CNT_W;
  - function clamp_div.
- No sub-module: a single counter/register block is the natural size.

Test Plan (CLK_HZ=8, TICK_HZ=1, so DIV_RST=8, CNT_W=4):
- Release rst_n, en=1 → cnt steps 0..7. tick is high for one cycle at 8, 16 and 24 cycles after the first enabled edge.
- en=0 for 5 cycles at cnt=3 → cnt holds at 3 and there is no tick. The next tick arrives exactly 5 cycles later than nominal.
- div_load=1, div_val=3 at cnt=2 → div_pend=1 until the wrap after cnt=7. After that, tick every 3 cycles and div_pend=0.
- div_val=0 and div_val=1 loads → the effective period is 2 cycles.
- sync_clr at cnt=5 with div_load (div_val=4) in the same cycle → cnt=0, no tick, div_cur stays 8, div_pend=1. Divisor 4 applies after the next wrap.
- rst_n pulsed low mid-period with a load pending → all outputs return to reset values, div_pend=0, and the period returns to 8. With TICK_GEN_SQUARE_EN defined, sq_out shows 4 cycles low, then 4 high.
